// File: rtl/nibble_serial_cla_subtractor_pkg.sv
// Shared definitions for the nibble-serial CLA subtractor.
//   NIBBLE_W  : width of one carry-lookahead slice (4 bits)
//   state_t   : controller states IDLE / RUN / DONE
//   cnt_width : bit width of the nibble counter, clog2(n) but never below 1
package nibble_serial_cla_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_cla_subtractor_cla_nibble_sub.sv
// cla_nibble_sub: combinational 4-bit carry-lookahead slice computing
// a + ~b + cin, i.e. a - b when cin=1 (carry convention: carry = ~borrow).
//   a, b  : 4-bit operands (b inverted inside the slice)
//   cin   : carry into bit 0
//   diff  : 4-bit sum/difference
//   cout  : carry out of bit 3
//   c3    : carry into bit 3, used for the signed overflow flag
module cla_nibble_sub
  import nibble_serial_cla_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_gp
    assign g[gi] = a[gi] & ~b[gi];
    assign p[gi] = a[gi] ^ ~b[gi];
  end

  // Flat lookahead: every carry is a two-level function of g, p and cin,
  // so the slice depth does not grow with bit position.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign diff = p ^ c[NIBBLE_W-1:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_cla_subtractor.sv
// nibble_serial_cla_subtractor: WIDTH-bit A - B - Bin computed one 4-bit CLA
// slice per clock, least-significant nibble first. Latency is N+1 edges from
// the accepting edge to the end of the o_Done pulse (N = WIDTH/4).
// Optional feature macro: SUB_OVERFLOW_FLAG_EN (adds o_Ovf, signed overflow).
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   i_Start        : request, sampled only while idle
//   i_A, i_B, i_Bin: operands, captured with an accepted start
//   o_Busy         : high while an operation is in flight (RUN and DONE)
//   o_Done         : one-cycle pulse, result valid
//   o_Diff, o_Bout : difference and borrow-out, held until next accepted start
//   o_Ovf          : signed overflow (only with SUB_OVERFLOW_FLAG_EN)
module nibble_serial_cla_subtractor
  import nibble_serial_cla_subtractor_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Bin,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Diff,
  output logic             o_Bout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             o_Ovf
`endif
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int CW = cnt_width(N);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;

  logic [NIBBLE_W-1:0] d_nib;
  logic                c_out;
  logic                c_msb;
  logic                last_nib;
  logic [WIDTH-1:0]    diff_next;

  cla_nibble_sub u_slice (
    .a    (a_reg[NIBBLE_W-1:0]),
    .b    (b_reg[NIBBLE_W-1:0]),
    .cin  (c_reg),
    .diff (d_nib),
    .cout (c_out),
    .c3   (c_msb)
  );

`ifndef SUB_OVERFLOW_FLAG_EN
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

  assign last_nib = (cnt_reg == CW'(N - 1));

  // New nibble enters at the top; after N shifts the register holds the
  // whole difference with nibble 0 at the bottom.
  if (N == 1) begin : g_one_nib
    assign diff_next = d_nib;
  end else begin : g_multi_nib
    assign diff_next = {d_nib, diff_reg[WIDTH-1:NIBBLE_W]};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Diff    <= '0;
      o_Bout    <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      o_Ovf     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          o_Done <= 1'b0;
          if (i_Start) begin
            a_reg     <= i_A;
            b_reg     <= i_B;
            c_reg     <= ~i_Bin;  // subtract as A + ~B + 1 - Bin
            cnt_reg   <= '0;
            o_Busy    <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg    <= a_reg >> NIBBLE_W;
          b_reg    <= b_reg >> NIBBLE_W;
          diff_reg <= diff_next;
          c_reg    <= c_out;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_nib) begin
            o_Diff    <= diff_next;
            o_Bout    <= ~c_out;
`ifdef SUB_OVERFLOW_FLAG_EN
            o_Ovf     <= c_msb ^ c_out;
`endif
            o_Done    <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          o_Done    <= 1'b0;
          o_Busy    <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
